trace_retire_buffer: RTL

Synthesizable, parametrised retirement-trace capture buffer. It accepts up to NRET retired-instruction records per cycle from the core's retire ports and tags each with a sequence number, cycle stamp and lane index. Records are queued in a DEPTH-entry FIFO and drained one per cycle over a valid/ready stream to an on-chip trace sink or debug port. It is the hardware successor to the simulation-only text tracer: same retire information, multi-lane, back-pressured, with drop accounting.

---
 rtl/trace_ret_pkg.sv | 38 +++
 rtl/trace_ret_fifo.sv | 49 ++++
 rtl/trace_retire_buffer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/trace_ret_pkg.sv
// Shared record type, record width and lane-rank helper for the retirement trace buffer.
// Optional memory-access fields are enabled by TRACE_RET_MEM_EN.
package trace_ret_pkg;

    // The cycle stamp is carried at 32 bits so the record width is a package constant.
    // A narrower CYCW counter is zero-extended into this field.
    typedef struct packed {
        logic [15:0] seq;
        logic [31:0] cycle;
        logic [1:0]  lane;
        logic        gap;
        logic [31:0] pc;
        logic [31:0] insn;
        logic        rd_wren;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
`ifdef TRACE_RET_MEM_EN
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
`endif
    } trace_rec_t;

    localparam int unsigned REC_W = $bits(trace_rec_t);

    // Number of valid lanes strictly below 'lane'; this is the lane's write slot.
    function automatic logic [2:0] lane_rank(input logic [3:0] valid, input logic [1:0] lane);
        logic [2:0] r;
        r = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if ((i < 32'(lane)) && valid[i]) begin
                r = r + 3'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/trace_ret_fifo.sv
// Multi-write (up to NRET per cycle), single-read FIFO with occupancy level and flush.
module trace_ret_fifo #(
    parameter int unsigned NRET  = 2,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [2:0]                     wr_cnt,
    input  logic [NRET-1:0][W-1:0]         wr_data,
    input  logic                           rd_en,
    output logic [W-1:0]                   rd_data,
    output logic [$clog2(DEPTH):0]         level,
    output logic                           full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            wptr  <= wptr + AW'(wr_cnt);
            rptr  <= rptr + AW'(rd_en);
            level <= level + LW'(wr_cnt) - LW'(rd_en);
        end
    end

    // Slots are compacted by the caller; pointer arithmetic wraps across the end.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NRET; i++) begin
            if (3'(i) < wr_cnt) begin
                mem[wptr + AW'(i)] <= wr_data[i];
            end
        end
    end

    assign rd_data = (level != '0) ? mem[rptr] : '0;
    assign full    = (level == LW'(DEPTH));

endmodule

// File: rtl/trace_retire_buffer.sv
// Retirement-trace capture buffer: tags multi-lane retires and queues them for a valid/ready sink.
// Memory-access fields and ports are present only when TRACE_RET_MEM_EN is defined.
module trace_retire_buffer
    import trace_ret_pkg::*;
#(
    parameter int unsigned NRET  = 2,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CYCW  = 32,
    parameter int unsigned DCW   = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic [NRET-1:0]         ret_valid_i,
    input  logic [NRET*32-1:0]      ret_pc_i,
    input  logic [NRET*32-1:0]      ret_insn_i,
    input  logic [NRET-1:0]         ret_rd_wren_i,
    input  logic [NRET*5-1:0]       ret_rd_addr_i,
    input  logic [NRET*32-1:0]      ret_rd_wdata_i,
`ifdef TRACE_RET_MEM_EN
    input  logic [NRET*32-1:0]      ret_mem_addr_i,
    input  logic [NRET*4-1:0]       ret_mem_rmask_i,
    input  logic [NRET*4-1:0]       ret_mem_wmask_i,
`endif
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output trace_rec_t              out_rec_o,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic                    full_o,
    output logic [DCW-1:0]          drop_cnt_o
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic [15:0]              seq;
    logic [CYCW-1:0]          cycle;
    logic                     gap_pend;
    logic [DCW-1:0]           drop_cnt;
    logic [2:0]               k;
    logic [2:0]               rank [NRET];
    logic [3:0]               valid4;
    logic                     pop;
    logic [LW:0]              free;
    logic                     admit;
    logic                     drop;
    logic [DCW:0]             drop_sum;
    trace_rec_t               lane_rec [NRET];
    logic [NRET-1:0][REC_W-1:0] wr_data;
    logic [REC_W-1:0]         head;

    assign valid4 = 4'(ret_valid_i);

    always_comb begin
        k = '0;
        for (int unsigned l = 0; l < NRET; l++) begin
            rank[l] = lane_rank(valid4, 2'(l));
            k       = k + 3'(ret_valid_i[l]);
        end
    end

    assign pop   = out_valid_o & out_ready_i;
    assign free  = (LW + 1)'(DEPTH) - {1'b0, level_o} + (LW + 1)'(pop);
    assign admit = !flush_i && (k != '0) && ((LW + 1)'(k) <= free);
    assign drop  = (k != '0) && (flush_i || ((LW + 1)'(k) > free));

    always_comb begin
        for (int unsigned l = 0; l < NRET; l++) begin
            lane_rec[l]          = '0;
            lane_rec[l].seq      = seq + 16'(rank[l]);
            lane_rec[l].cycle    = 32'(cycle);
            lane_rec[l].lane     = 2'(l);
            lane_rec[l].gap      = gap_pend && (rank[l] == '0);
            lane_rec[l].pc       = ret_pc_i[32*l +: 32];
            lane_rec[l].insn     = ret_insn_i[32*l +: 32];
            lane_rec[l].rd_wren  = ret_rd_wren_i[l];
            lane_rec[l].rd_addr  = ret_rd_wren_i[l] ? ret_rd_addr_i[5*l +: 5] : '0;
            lane_rec[l].rd_wdata = ret_rd_wren_i[l] ? ret_rd_wdata_i[32*l +: 32] : '0;
`ifdef TRACE_RET_MEM_EN
            lane_rec[l].mem_addr  = ret_mem_addr_i[32*l +: 32];
            lane_rec[l].mem_rmask = ret_mem_rmask_i[4*l +: 4];
            lane_rec[l].mem_wmask = ret_mem_wmask_i[4*l +: 4];
`endif
        end
    end

    // Compact valid lanes into consecutive write slots in ascending lane order.
    always_comb begin
        wr_data = '0;
        for (int unsigned s = 0; s < NRET; s++) begin
            for (int unsigned l = 0; l < NRET; l++) begin
                if (ret_valid_i[l] && (rank[l] == 3'(s))) begin
                    wr_data[s] = lane_rec[l];
                end
            end
        end
    end

    assign drop_sum = {1'b0, drop_cnt} + (DCW + 1)'(k);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            seq      <= '0;
            cycle    <= '0;
            gap_pend <= 1'b0;
            drop_cnt <= '0;
        end else begin
            cycle <= cycle + CYCW'(1);
            seq   <= seq + 16'(k);
            if (drop) begin
                drop_cnt <= drop_sum[DCW] ? '1 : drop_sum[DCW-1:0];
                gap_pend <= 1'b1;
            end else if (admit) begin
                gap_pend <= 1'b0;
            end
        end
    end

    trace_ret_fifo #(
        .NRET  (NRET),
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .flush   (flush_i),
        .wr_cnt  (admit ? k : 3'd0),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .level   (level_o),
        .full    (full_o)
    );

    assign out_valid_o = (level_o != '0);
    assign out_rec_o   = head;
    assign drop_cnt_o  = drop_cnt;

endmodule
